led_pattern_monitor: RTL and testbench

Passive observer on the 16-bit LED bus driven by the bound flasher. It samples the bus every clock, classifies each cycle-to-cycle change as hold, fill-up, drain-down or illegal, and tracks the flasher's sequence phase with its own FSM. It reports phase, completed-sequence, kickback (flick-induced reversal), abort and error events. It sits beside the flasher in the top level and feeds status and debug logic. It never drives the LED bus.

---
 rtl/led_mon_pkg.sv | 35 +++
 rtl/led_step_classifier.sv | 19 +
 rtl/led_pattern_monitor.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_mon_pkg.sv
// Shared types and pattern constants for the LED bus monitor.
package led_mon_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_R1   = 3'd1,
    PH_F1   = 3'd2,
    PH_R2   = 3'd3,
    PH_F2   = 3'd4,
    PH_R3   = 3'd5,
    PH_F3   = 3'd6,
    PH_ERR  = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    STEP_HOLD = 3'd0,
    STEP_UP   = 3'd1,
    STEP_DOWN = 3'd2,
    STEP_ZERO = 3'd3,
    STEP_BAD  = 3'd4
  } step_e;

  localparam logic [15:0] P4  = 16'h001F;
  localparam logic [15:0] P5  = 16'h003F;
  localparam logic [15:0] P10 = 16'h07FF;
  localparam logic [15:0] P15 = 16'hFFFF;

  // Thermometer code: contiguous ones from bit 0 (zero included).
  function automatic logic is_therm(input logic [15:0] v);
    logic [15:0] inc;
    inc = v + 16'd1;
    return ((v & inc) == 16'd0);
  endfunction

endpackage

// File: rtl/led_step_classifier.sv
// Combinational classification of one bus sample against the previous one.
module led_step_classifier
  import led_mon_pkg::*;
(
  input  logic [15:0] prev_i,
  input  logic [15:0] leds_i,
  output step_e       step_o
);

  always_comb begin
    step_o = STEP_BAD;
    if (!is_therm(leds_i))                    step_o = STEP_BAD;
    else if (leds_i == prev_i)                step_o = STEP_HOLD;
    else if (leds_i == {prev_i[14:0], 1'b1})  step_o = STEP_UP;
    else if (leds_i == (prev_i >> 1))         step_o = STEP_DOWN;
    else if (leds_i == 16'd0)                 step_o = STEP_ZERO;
  end

endmodule

// File: rtl/led_pattern_monitor.sv
// Passive monitor tracking the flasher's phase on the LED bus.
// Event counters are built only when LED_MON_COUNT_EN is defined.
module led_pattern_monitor
  import led_mon_pkg::*;
#(
  parameter int STALL_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] leds,
  output logic [2:0]  phase,
  output logic        active,
  output logic        done_pulse,
  output logic        kick_pulse,
  output logic        abort_pulse,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [7:0]  seq_count,
  output logic [7:0]  kick_count
);

  localparam int STALL_W = $clog2(STALL_MAX + 2);

  logic [15:0]        leds_q, prev_q;
  step_e              step;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stall_hit;
  phase_e             phase_q, phase_d;
  logic               active_q, done_q, kick_q, abort_q, err_q, sticky_q;
  logic               done_d, kick_d, abort_d, err_d;
  logic               legal, up;

  led_step_classifier u_cls (
    .prev_i (prev_q),
    .leds_i (leds_q),
    .step_o (step)
  );

  // The counter parks at STALL_MAX+1 so a long stall reports only once.
  always_comb begin
    stall_d = '0;
    if (step == STEP_HOLD && leds_q != 16'd0)
      stall_d = (stall_q == STALL_W'(STALL_MAX + 1)) ? stall_q : stall_q + 1'b1;
  end

  assign stall_hit = (step == STEP_HOLD) && (leds_q != 16'd0) &&
                     (stall_q == STALL_W'(STALL_MAX));

  always_comb begin
    phase_d = phase_q;
    done_d  = 1'b0;
    kick_d  = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    legal   = 1'b0;
    up      = (step == STEP_UP);
    if (stall_hit || step == STEP_BAD) begin
      err_d   = 1'b1;
      phase_d = PH_ERR;
    end else if (phase_q == PH_ERR) begin
      if (leds_q == 16'd0 && prev_q == 16'd0) phase_d = PH_IDLE;
    end else if (step == STEP_ZERO) begin
      abort_d = 1'b1;
      phase_d = PH_IDLE;
    end else if (step == STEP_UP || step == STEP_DOWN) begin
      case (phase_q)
        PH_IDLE: if (up && leds_q == 16'h0001) begin legal = 1'b1; phase_d = PH_R1; end
        PH_R1: begin
          if (up && leds_q <= P5) legal = 1'b1;
          else if (!up && prev_q == P5) begin legal = 1'b1; phase_d = PH_F1; end
        end
        PH_F1: begin
          if (!up) legal = 1'b1;
          else if (prev_q == 16'd0) begin legal = 1'b1; phase_d = PH_R2; end
        end
        PH_R2: begin
          if (up && leds_q <= P10) legal = 1'b1;
          else if (!up && prev_q == P10) begin legal = 1'b1; phase_d = PH_F2; end
          else if (!up && prev_q == P5) begin legal = 1'b1; phase_d = PH_F1; kick_d = 1'b1; end
        end
        PH_F2: begin
          if (!up && prev_q > P4) legal = 1'b1;
          else if (prev_q == P4) begin
            legal   = 1'b1;
            phase_d = up ? PH_R3 : PH_F1;
            kick_d  = !up;
          end
        end
        PH_R3: begin
          if (up) legal = 1'b1;
          else if (prev_q == P15) begin legal = 1'b1; phase_d = PH_F3; end
          else if (prev_q == P5 || prev_q == P10) begin
            legal = 1'b1; phase_d = PH_F2; kick_d = 1'b1;
          end
        end
        PH_F3: begin
          if (!up) begin
            legal = 1'b1;
            if (leds_q == 16'd0) begin phase_d = PH_IDLE; done_d = 1'b1; end
          end
        end
        default: legal = 1'b0;
      endcase
      if (!legal) begin
        err_d   = 1'b1;
        kick_d  = 1'b0;
        done_d  = 1'b0;
        phase_d = PH_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q   <= '0;
      prev_q   <= '0;
      stall_q  <= '0;
      phase_q  <= PH_IDLE;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      kick_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      leds_q   <= leds;
      prev_q   <= leds_q;
      stall_q  <= stall_d;
      phase_q  <= phase_d;
      active_q <= (phase_d != PH_IDLE) && (phase_d != PH_ERR);
      done_q   <= done_d;
      kick_q   <= kick_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      sticky_q <= sticky_q | err_d;
    end
  end

  assign phase       = phase_q;
  assign active      = active_q;
  assign done_pulse  = done_q;
  assign kick_pulse  = kick_q;
  assign abort_pulse = abort_q;
  assign err_pulse   = err_q;
  assign err_sticky  = sticky_q;

`ifdef LED_MON_COUNT_EN
  logic [7:0] seq_cnt_q, kick_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_cnt_q  <= '0;
      kick_cnt_q <= '0;
    end else begin
      if (done_d && seq_cnt_q != 8'hFF)  seq_cnt_q  <= seq_cnt_q + 8'd1;
      if (kick_d && kick_cnt_q != 8'hFF) kick_cnt_q <= kick_cnt_q + 8'd1;
    end
  end

  assign seq_count  = seq_cnt_q;
  assign kick_count = kick_cnt_q;
`else
  assign seq_count  = 8'd0;
  assign kick_count = 8'd0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Scoreboard bench for led_pattern_monitor: each driven sample queues its expected outputs two edges later.
module tb_led_pattern_monitor;

  localparam int SMAX = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_R1 = 3'd1, S_F1 = 3'd2, S_R2 = 3'd3;
  localparam logic [2:0] S_F2 = 3'd4, S_R3 = 3'd5, S_F3 = 3'd6, S_ERR = 3'd7;
  localparam int EV_NONE = 0, EV_DONE = 1, EV_KICK = 2, EV_ABORT = 3, EV_ERR = 4;
`ifdef LED_MON_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] leds = '0;
  logic [2:0]  phase;
  logic        active, done_pulse, kick_pulse, abort_pulse, err_pulse, err_sticky;
  logic [7:0]  seq_count, kick_count;
  logic [7:0]  obs;

  led_pattern_monitor #(.STALL_MAX(SMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .leds        (leds),
    .phase       (phase),
    .active      (active),
    .done_pulse  (done_pulse),
    .kick_pulse  (kick_pulse),
    .abort_pulse (abort_pulse),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .seq_count   (seq_count),
    .kick_count  (kick_count)
  );

  assign obs = {phase, active, done_pulse, kick_pulse, abort_pulse, err_pulse};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] v; logic [7:0] exp; } stim_t;
  typedef struct { int due; logic [7:0] exp; } exp_t;
  stim_t stim_q[$];
  exp_t  exp_q[$];
  stim_t st;
  exp_t  ex;
  int    n_chk = 0, n_pass = 0;
  int    exp_seq = 0, exp_kick = 0;
  logic [7:0] exp_seq8, exp_kick8;

  function automatic logic [15:0] therm(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic push(input logic [15:0] v, input logic [2:0] ph, input int ev);
    logic [7:0] e;
    e = {ph, (ph != S_IDLE && ph != S_ERR), ev == EV_DONE, ev == EV_KICK,
         ev == EV_ABORT, ev == EV_ERR};
    stim_q.push_back('{v, e});
  endtask

  // Walks the thermometer level from a to b (a excluded), one step per sample.
  task automatic ramp(input int a, input int b, input logic [2:0] ph);
    if (a < b) for (int n = a + 1; n <= b; n++) push(therm(n), ph, EV_NONE);
    else       for (int n = a - 1; n >= b; n--) push(therm(n), ph, EV_NONE);
  endtask

  task automatic test_reset();
    rst = 1'b0; leds = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (obs !== 8'h00) $display("FAIL reset_outputs got=%b exp=%b", obs, 8'h00); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL reset_sticky got=%b exp=0", err_sticky); else n_pass++;
    n_chk++; if ({seq_count, kick_count} !== 16'h0) $display("FAIL reset_counts got=%h exp=0000", {seq_count, kick_count}); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    ramp(0, 6, S_R1); push(therm(6), S_R1, EV_NONE); push(therm(6), S_R1, EV_NONE);
    ramp(6, 0, S_F1); push(16'h0, S_F1, EV_NONE);
    ramp(0, 11, S_R2); push(therm(11), S_R2, EV_NONE);
    ramp(11, 5, S_F2); ramp(5, 16, S_R3);
    push(therm(16), S_R3, EV_NONE); push(therm(16), S_R3, EV_NONE); push(therm(16), S_R3, EV_NONE);
    ramp(16, 1, S_F3); push(16'h0, S_IDLE, EV_DONE);
    exp_seq++;
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL clean cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    exp_seq8 = CNT_EN ? 8'(exp_seq) : 8'd0;
    n_chk++; if (seq_count !== exp_seq8) $display("FAIL clean_seq_count got=%0d exp=%0d", seq_count, exp_seq8); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL clean_sticky got=%b exp=0", err_sticky); else n_pass++;
  endtask

  task automatic test_kick_r2();
    ramp(0, 6, S_R1); ramp(6, 0, S_F1); ramp(0, 6, S_R2);
    push(therm(5), S_F1, EV_KICK); ramp(5, 0, S_F1);
    ramp(0, 11, S_R2); ramp(11, 5, S_F2); ramp(5, 16, S_R3); ramp(16, 1, S_F3);
    push(16'h0, S_IDLE, EV_DONE);
    exp_seq++; exp_kick++;
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL kick_r2 cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    exp_seq8 = CNT_EN ? 8'(exp_seq) : 8'd0;
    exp_kick8 = CNT_EN ? 8'(exp_kick) : 8'd0;
    n_chk++; if (kick_count !== exp_kick8) $display("FAIL kick_r2_kick_count got=%0d exp=%0d", kick_count, exp_kick8); else n_pass++;
    n_chk++; if (seq_count !== exp_seq8) $display("FAIL kick_r2_seq_count got=%0d exp=%0d", seq_count, exp_seq8); else n_pass++;
  endtask

  task automatic test_kick_r3();
    ramp(0, 6, S_R1); ramp(6, 0, S_F1); ramp(0, 11, S_R2); ramp(11, 5, S_F2);
    ramp(5, 11, S_R3); push(therm(10), S_F2, EV_KICK); ramp(10, 5, S_F2);
    ramp(5, 16, S_R3); ramp(16, 1, S_F3); push(16'h0, S_IDLE, EV_DONE);
    exp_seq++; exp_kick++;
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL kick_r3 cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    exp_kick8 = CNT_EN ? 8'(exp_kick) : 8'd0;
    n_chk++; if (kick_count !== exp_kick8) $display("FAIL kick_r3_kick_count got=%0d exp=%0d", kick_count, exp_kick8); else n_pass++;
  endtask

  task automatic test_abort();
    ramp(0, 4, S_R1); push(16'h0, S_IDLE, EV_ABORT); push(16'h0, S_IDLE, EV_NONE);
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL abort cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL abort_sticky got=%b exp=0", err_sticky); else n_pass++;
  endtask

  task automatic test_illegal();
    ramp(0, 3, S_R1); push(16'h0005, S_ERR, EV_ERR);
    push(16'h0, S_ERR, EV_NONE); push(16'h0, S_IDLE, EV_NONE);
    ramp(0, 6, S_R1); push(therm(7), S_ERR, EV_ERR);
    push(16'h0, S_ERR, EV_NONE); push(16'h0, S_IDLE, EV_NONE);
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL illegal cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    n_chk++; if (err_sticky !== 1'b1) $display("FAIL illegal_sticky got=%b exp=1", err_sticky); else n_pass++;
  endtask

  task automatic test_stall();
    ramp(0, 2, S_R1);
    for (int i = 0; i < SMAX; i++) push(16'h0003, S_R1, EV_NONE);
    push(16'h0003, S_ERR, EV_ERR);
    push(16'h0, S_ERR, EV_NONE); push(16'h0, S_IDLE, EV_NONE);
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
  endtask

  task automatic test_reset_mid();
    ramp(0, 6, S_R1); ramp(6, 0, S_F1); ramp(0, 4, S_R2);
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
    #2 rst = 1'b0; leds = 16'h0001;
    #1;
    n_chk++; if (obs !== 8'h00) $display("FAIL reset_mid_outputs got=%b exp=%b", obs, 8'h00); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL reset_mid_sticky got=%b exp=0", err_sticky); else n_pass++;
    n_chk++; if ({seq_count, kick_count} !== 16'h0) $display("FAIL reset_mid_counts got=%h exp=0000", {seq_count, kick_count}); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (obs !== {S_R1, 5'b10000}) $display("FAIL reset_release got=%b exp=%b", obs, {S_R1, 5'b10000}); else n_pass++;
    push(16'h0003, S_R1, EV_NONE); push(16'h0007, S_R1, EV_NONE);
    while (stim_q.size() != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front(); n_chk++;
        if (obs !== ex.exp) $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", cyc, obs, ex.exp); else n_pass++;
      end
      if (stim_q.size() != 0) begin st = stim_q.pop_front(); leds = st.v; exp_q.push_back('{cyc + 2, st.exp}); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_kick_r2();
    test_kick_r3();
    test_abort();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
